// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per clock, stalls the core until done
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic sa, sb, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] b, mag_a, mag_b, quo, rem, res_calc;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN:0] msum;
  logic [XLEN+1:0] diff;
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sgn_a = funct3[2] ? ~funct3[0] : funct3[1] ^ funct3[0];
    sgn_b = funct3[2] ? ~funct3[0] : funct3[1:0] == 2'b01;
    neg_a = sgn_a & op_a[XLEN-1];
    neg_b = sgn_b & op_b[XLEN-1];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;
    msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
    diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, b};
    acc_nxt = !f3[2] ? {msum, acc[XLEN-1:1]} :
              diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0} :
              {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod = (sa ^ sb) ? -acc_nxt : acc_nxt;
    quo = acc_nxt[XLEN-1:0];
    rem = acc_nxt[2*XLEN-1:XLEN];
    res_calc = !f3[2] ? (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
               !f3[1] ? ((sa ^ sb) ? -quo : quo) :
               (sa ? -rem : rem);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      b <= '0;
      acc <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3 <= funct3;
          if (funct3[2] && op_b == '0) begin
            result <= funct3[1] ? op_a : '1;
            state <= DONE;
          end else begin
            sa <= neg_a;
            sb <= neg_b;
            b <= mag_b;
            acc <= {{XLEN{1'b0}}, mag_a};
            cnt <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            result <= res_calc;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state == CALC;
  assign done = state == DONE;
  assign stall = ~rst & ((state == IDLE & start) | (state == CALC));
endmodule
